// File: rtl/messbauer_diff_discriminator_counter_if.sv
// Bundle between the discriminator front end, the pulse counter and the spectrum writer.
// Handshake: a result moves when count_valid and count_ready are both high on a rising aclk;
// the producer holds count_data/count_channel stable while count_valid is high and count_ready is low.
interface messbauer_diff_discriminator_counter_if #(
  parameter int COUNTER_WIDTH = 16,
  parameter int CHANNEL_WIDTH = 10
);
  logic                     lower_threshold;
  logic                     upper_threshold;
  logic                     channel;
  logic [COUNTER_WIDTH-1:0] count_data;
  logic [CHANNEL_WIDTH-1:0] count_channel;
  logic                     count_valid;
  logic                     count_ready;
  logic                     accepted;
  logic                     rejected;
  logic                     overrun;

  modport master (
    input  lower_threshold,
    input  upper_threshold,
    input  channel,
    input  count_ready,
    output count_data,
    output count_channel,
    output count_valid,
    output accepted,
    output rejected,
    output overrun
  );

  modport slave (
    output lower_threshold,
    output upper_threshold,
    output channel,
    output count_ready,
    input  count_data,
    input  count_channel,
    input  count_valid,
    input  accepted,
    input  rejected,
    input  overrun
  );
endinterface

// File: rtl/messbauer_diff_discriminator_counter.sv
// Classifies lower/upper discriminator pulses and hands per-channel accepted counts downstream.
// Optional input synchronizers: define MESSBAUER_DISCR_SYNC_EN.
module messbauer_diff_discriminator_counter #(
  parameter int COUNTER_WIDTH      = 16,
  parameter int CHANNEL_WIDTH      = 10,
  parameter int MIN_LOWER_DURATION = 2
) (
  input  logic                                          aclk,
  input  logic                                          areset,
  messbauer_diff_discriminator_counter_if.master        bus,
  output logic [1:0]                                    fsm_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PULSE  = 2'd1,
    ST_REJECT = 2'd2
  } state_t;

  localparam logic [7:0]               MIN_W   = 8'(MIN_LOWER_DURATION);
  localparam logic [7:0]               WIDTH_MAX = 8'hFF;
  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;

  logic lower_in;
  logic upper_in;
  logic channel_in;

`ifdef MESSBAUER_DISCR_SYNC_EN
  // Synchronizer flops carry no reset so they always track the pins; this keeps
  // a lower level already high at reset release from looking like a fresh rise.
  logic [1:0] lower_sync;
  logic [1:0] upper_sync;
  logic [1:0] channel_sync;

  always_ff @(posedge aclk) begin
    lower_sync   <= {lower_sync[0],   bus.lower_threshold};
    upper_sync   <= {upper_sync[0],   bus.upper_threshold};
    channel_sync <= {channel_sync[0], bus.channel};
  end

  assign lower_in   = lower_sync[1];
  assign upper_in   = upper_sync[1];
  assign channel_in = channel_sync[1];
`else
  assign lower_in   = bus.lower_threshold;
  assign upper_in   = bus.upper_threshold;
  assign channel_in = bus.channel;
`endif

  // Stage S and stage D registers plus the lower-level arming flag
  logic lower_s;
  logic lower_d;
  logic upper_s;
  logic channel_s;
  logic channel_d;
  logic armed;

  always_ff @(posedge aclk) begin
    if (areset) begin
      lower_s   <= 1'b0;
      lower_d   <= 1'b0;
      upper_s   <= 1'b0;
      channel_s <= 1'b0;
      channel_d <= 1'b0;
      armed     <= 1'b0;
    end else begin
      lower_s   <= lower_in;
      lower_d   <= lower_s;
      upper_s   <= upper_in;
      channel_s <= channel_in;
      channel_d <= channel_s;
      if (!lower_in) begin
        armed <= 1'b1;
      end
    end
  end

  logic lower_rise;
  logic lower_fall;
  logic channel_rise;

  // A rise only counts once lower has been seen low since reset.
  assign lower_rise   = lower_s & ~lower_d & armed;
  assign lower_fall   = ~lower_s & lower_d;
  assign channel_rise = channel_s & ~channel_d;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] width;
  logic [7:0] width_nxt;
  logic [7:0] width_inc;
  logic       width_long;
  logic       accept_evt;
  logic       reject_evt;

  assign width_inc  = (width == WIDTH_MAX) ? width : width + 8'd1;
  assign width_long = (width >= MIN_W);

  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= ST_IDLE;
      width <= 8'd0;
    end else begin
      state <= state_nxt;
      width <= width_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (lower_rise) begin
          state_nxt = upper_s ? ST_REJECT : ST_PULSE;
        end
      end
      ST_PULSE: begin
        if (lower_fall) begin
          state_nxt = ST_IDLE;
        end else if (upper_s) begin
          state_nxt = ST_REJECT;
        end
      end
      ST_REJECT: begin
        if (lower_fall) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The fall cycle has lower already low, so upper seen then is outside the pulse.
  always_comb begin
    width_nxt  = width;
    accept_evt = 1'b0;
    reject_evt = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (lower_rise) begin
          width_nxt = 8'd1;
        end
      end
      ST_PULSE: begin
        if (lower_fall) begin
          accept_evt = width_long;
        end else begin
          width_nxt = width_inc;
        end
      end
      ST_REJECT: begin
        if (lower_fall) begin
          reject_evt = width_long;
        end else begin
          width_nxt = width_inc;
        end
      end
      default: width_nxt = 8'd0;
    endcase
  end

  assign fsm_state = state;

  logic [COUNTER_WIDTH-1:0] count;
  logic [COUNTER_WIDTH-1:0] count_folded;
  logic [CHANNEL_WIDTH-1:0] index;
  logic [COUNTER_WIDTH-1:0] count_data_q;
  logic [CHANNEL_WIDTH-1:0] count_channel_q;
  logic                     count_valid_q;
  logic                     accepted_q;
  logic                     rejected_q;
  logic                     overrun_q;

  // An accept landing in the closing cycle still belongs to the closing channel.
  assign count_folded = (accept_evt && (count != CNT_MAX)) ? count + COUNTER_WIDTH'(1) : count;

  always_ff @(posedge aclk) begin
    if (areset) begin
      count           <= '0;
      index           <= '0;
      count_data_q    <= '0;
      count_channel_q <= '0;
      count_valid_q   <= 1'b0;
      accepted_q      <= 1'b0;
      rejected_q      <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      accepted_q <= accept_evt;
      rejected_q <= reject_evt;
      if (channel_rise) begin
        count <= '0;
        index <= index + CHANNEL_WIDTH'(1);
        if (!count_valid_q || bus.count_ready) begin
          count_data_q    <= count_folded;
          count_channel_q <= index;
          count_valid_q   <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else begin
        count <= count_folded;
        if (count_valid_q && bus.count_ready) begin
          count_valid_q <= 1'b0;
        end
      end
    end
  end

  assign bus.count_data    = count_data_q;
  assign bus.count_channel = count_channel_q;
  assign bus.count_valid   = count_valid_q;
  assign bus.accepted      = accepted_q;
  assign bus.rejected      = rejected_q;
  assign bus.overrun       = overrun_q;

endmodule

// File: tb/tb_messbauer_diff_discriminator_counter.sv
// Bench for messbauer_diff_discriminator_counter: directed steps plus randomized pulse trains,
// with a 16-bit and a 4-bit counter instance fed from the same stimulus.
module tb_messbauer_diff_discriminator_counter;
  localparam int CW      = 16;
  localparam int CW4     = 4;
  localparam int NW      = 10;
  localparam int MIN_DUR = 2;
  localparam int NCH     = 1 << NW;
  localparam int MAX4    = (1 << CW4) - 1;

  // ---------------- clock / reset ----------------
  logic aclk = 1'b0;
  logic areset;
  always #5 aclk = ~aclk;

  messbauer_diff_discriminator_counter_if #(.COUNTER_WIDTH(CW),  .CHANNEL_WIDTH(NW)) bus  ();
  messbauer_diff_discriminator_counter_if #(.COUNTER_WIDTH(CW4), .CHANNEL_WIDTH(NW)) bus4 ();
  logic [1:0] fsm_state;
  logic [1:0] fsm_state4;

  assign bus4.lower_threshold = bus.lower_threshold;
  assign bus4.upper_threshold = bus.upper_threshold;
  assign bus4.channel         = bus.channel;
  assign bus4.count_ready     = bus.count_ready;

  messbauer_diff_discriminator_counter #(
    .COUNTER_WIDTH(CW), .CHANNEL_WIDTH(NW), .MIN_LOWER_DURATION(MIN_DUR)
  ) dut (
    .aclk(aclk), .areset(areset), .bus(bus.master), .fsm_state(fsm_state)
  );

  messbauer_diff_discriminator_counter #(
    .COUNTER_WIDTH(CW4), .CHANNEL_WIDTH(NW), .MIN_LOWER_DURATION(MIN_DUR)
  ) dut4 (
    .aclk(aclk), .areset(areset), .bus(bus4.master), .fsm_state(fsm_state4)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  int model_cnt = 0;
  int model_idx = 0;
  int acc_exp = 0, rej_exp = 0;
  int acc_seen = 0, rej_seen = 0;
  logic [CW+NW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Each one-cycle strobe and each completed handshake is seen at exactly one negedge.
  always @(negedge aclk) begin
    if (!areset) begin
      if (bus.accepted) acc_seen++;
      if (bus.rejected) rej_seen++;
      if (bus.count_valid && bus.count_ready) begin
        if (exp_q.size() == 0) begin
          check("handshake_with_no_expected_result", 32'(exp_q.size()), 1);
        end else begin
          logic [CW+NW-1:0] e;
          int ecnt;
          e    = exp_q.pop_front();
          ecnt = int'(e[CW+NW-1:NW]);
          check("count_data",    32'(bus.count_data),    32'(ecnt));
          check("count_channel", 32'(bus.count_channel), 32'(e[NW-1:0]));
          check("count_data_w4", 32'(bus4.count_data),   32'((ecnt > MAX4) ? MAX4 : ecnt));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    tick();
    tick();
    @(negedge aclk);
    check("rst_count_valid",   32'(bus.count_valid),   0);
    check("rst_count_data",    32'(bus.count_data),    0);
    check("rst_count_channel", 32'(bus.count_channel), 0);
    check("rst_accepted",      32'(bus.accepted),      0);
    check("rst_rejected",      32'(bus.rejected),      0);
    check("rst_overrun",       32'(bus.overrun),       0);
    tick();
    areset    = 1'b0;
    model_cnt = 0;
    model_idx = 0;
  endtask

  // Classification from the pulse's own description: too short -> nothing,
  // upper high in any cycle lower is high -> rejected, otherwise accepted.
  task automatic classify(input int len, input int upos);
    if (len >= MIN_DUR) begin
      if (upos >= 0 && upos < len) rej_exp++;
      else begin
        acc_exp++;
        model_cnt++;
      end
    end
  endtask

  task automatic pulse(input int len, input int upos);
    for (int i = 0; i < len; i++) begin
      tick();
      bus.lower_threshold = 1'b1;
      bus.upper_threshold = (i == upos);
    end
    tick();
    bus.lower_threshold = 1'b0;
    bus.upper_threshold = 1'b0;
    classify(len, upos);
  endtask

  task automatic model_close(input bit loads);
    if (loads) exp_q.push_back({CW'(model_cnt), NW'(model_idx)});
    model_cnt = 0;
    model_idx = (model_idx + 1) % NCH;
  endtask

  task automatic close_channel(input bit loads);
    tick();
    bus.channel = 1'b1;
    model_close(loads);
    tick();
    bus.channel = 1'b0;
  endtask

  task automatic settle_and_count(input string tag);
    repeat (4) tick();
    check({tag, "_accepted_total"}, 32'(acc_seen), 32'(acc_exp));
    check({tag, "_rejected_total"}, 32'(rej_seen), 32'(rej_exp));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int len, upos;
    bus.lower_threshold = 1'b0;
    bus.upper_threshold = 1'b0;
    bus.channel         = 1'b0;
    bus.count_ready     = 1'b1;
    do_reset();

    // Five clean pulses with strobe latency on the first, then a timed channel close.
    pulse(4, -1);
    @(posedge aclk);
    @(negedge aclk);
    check("accept_strobe_1_cycle_after_fall", 32'(bus.accepted), 0);
    @(posedge aclk);
    @(negedge aclk);
    check("accept_strobe_2_cycles_after_fall", 32'(bus.accepted), 1);
    repeat (4) pulse(4, -1);
    tick();
    bus.channel = 1'b1;
    model_close(1'b1);
    tick();
    bus.channel = 1'b0;
    @(negedge aclk);
    check("valid_1_cycle_after_channel", 32'(bus.count_valid), 0);
    @(posedge aclk);
    @(negedge aclk);
    check("valid_2_cycles_after_channel", 32'(bus.count_valid), 1);
    @(posedge aclk);
    @(negedge aclk);
    check("valid_drops_after_handshake", 32'(bus.count_valid), 0);
    settle_and_count("clean5");

    // Upper mid-pulse and at the first lower cycle are both rejections.
    pulse(4, 2);
    pulse(4, 1);
    pulse(4, 0);
    pulse(4, -1);
    pulse(4, -1);
    close_channel(1'b1);
    settle_and_count("reject3");

    // Glitches below the minimum width produce no strobe either way.
    pulse(1, -1);
    pulse(1, 0);
    settle_and_count("glitch");
    close_channel(1'b1);

    // Upper alone while idle, then upper overlapping only the fall cycle.
    tick(); bus.upper_threshold = 1'b1;
    tick(); bus.upper_threshold = 1'b0;
    pulse(3, -1);
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.lower_threshold = 1'b1;
    end
    tick();
    bus.lower_threshold = 1'b0;
    bus.upper_threshold = 1'b1;
    classify(3, -1);
    tick();
    bus.upper_threshold = 1'b0;
    settle_and_count("upper_outside_pulse");
    close_channel(1'b1);

    // Lower fall and channel rise on the same cycle after six accepts.
    repeat (6) pulse(4, -1);
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.lower_threshold = 1'b1;
    end
    tick();
    bus.lower_threshold = 1'b0;
    bus.channel         = 1'b1;
    classify(4, -1);
    model_close(1'b1);
    tick();
    bus.channel = 1'b0;
    close_channel(1'b1);
    settle_and_count("same_cycle_close");

    // Randomized pulse trains with stray upper pulses in the gaps.
    for (int n = 0; n < 150; n++) begin
      len  = int'($urandom_range(1, 6));
      upos = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      pulse(len, upos);
      if ($urandom_range(0, 2) == 0) begin
        tick(); bus.upper_threshold = 1'($urandom_range(0, 1));
        tick(); bus.upper_threshold = 1'b0;
      end
      if ($urandom_range(0, 7) == 0) close_channel(1'b1);
    end
    close_channel(1'b1);
    settle_and_count("random");

    // Twenty accepts: the 16-bit counter holds 20, the 4-bit one saturates at 15.
    repeat (20) pulse(3, -1);
    close_channel(1'b1);
    settle_and_count("saturate");

    // Overrun: the first result is held while the second close is discarded.
    do_reset();
    bus.count_ready = 1'b0;
    repeat (3) pulse(4, -1);
    close_channel(1'b1);
    repeat (10) tick();
    pulse(2, -1);
    close_channel(1'b0);
    repeat (3) tick();
    @(negedge aclk);
    check("held_count_valid",   32'(bus.count_valid),   1);
    check("held_count_data",    32'(bus.count_data),    3);
    check("held_count_channel", 32'(bus.count_channel), 0);
    check("overrun_set",        32'(bus.overrun),       1);
    tick();
    bus.count_ready = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    check("valid_drops_after_ready", 32'(bus.count_valid), 0);
    close_channel(1'b1);
    settle_and_count("overrun");
    check("overrun_sticky", 32'(bus.overrun), 1);

    // Reset in the middle of a pulse; lower still high at release is not counted.
    tick();
    bus.lower_threshold = 1'b1;
    repeat (3) tick();
    do_reset();
    repeat (3) tick();
    bus.lower_threshold = 1'b0;
    settle_and_count("reset_mid_pulse");
    close_channel(1'b1);

    // Walk the channel index through its wrap point.
    for (int i = 0; i < NCH; i++) close_channel(1'b1);
    pulse(4, -1);
    close_channel(1'b1);
    settle_and_count("wrap");
    check("result_queue_drained", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
